axis_demux3_route: RTL and testbench

// 1:3 AXI-Stream packet demultiplexer; egress counterpart of the 3:1 round-robin mux.
// - Takes one 512-bit packet stream and steers each whole packet to m0, m1 or m2.
// - The destination is taken from s0_tdest on the first beat of the packet.
// - Packets addressed to tdest=3, or to a disabled output, are consumed and dropped.
// - Drops are counted.
//

---
 rtl/axis_demux3_route_pkg.sv | 29 ++
 rtl/axis_demux3_route_if.sv | 26 ++
 rtl/axis_demux3_route_state_base.sv | 35 +++
 rtl/axis_demux3_route.sv | 164 ++++++++++++++++
 tb/tb_axis_demux3_route.sv | 269 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/axis_demux3_route_pkg.sv
// Shared stream types: one-hot channel codes (common with the 3:1 mux),
// demux FSM states and the reserved discard destination.
package axis_demux3_route_pkg;

  typedef enum logic [2:0] {
    CH_NONE = 3'b000,
    CH0     = 3'b001,
    CH1     = 3'b010,
    CH2     = 3'b100
  } ch_e;

  typedef enum logic [1:0] {
    IDLE,
    ROUTE,
    DROP
  } state_e;

  localparam logic [1:0] DEST_DISCARD = 2'd3;

  function automatic ch_e dest_to_ch(input logic [1:0] dest);
    case (dest)
      2'd0:    return CH0;
      2'd1:    return CH1;
      2'd2:    return CH2;
      default: return CH_NONE;
    endcase
  endfunction

endpackage

// File: rtl/axis_demux3_route_if.sv
// AXI-Stream bundle; master drives the payload, slave drives tready.
interface axis_demux3_route_if #(
  parameter int DATA_W = 512,
  parameter int KEEP_W = DATA_W / 8,
  parameter int USER_W = 1
) ();

  logic              tvalid;
  logic              tready;
  logic [DATA_W-1:0] tdata;
  logic [KEEP_W-1:0] tkeep;
  logic              tlast;
  logic [USER_W-1:0] tuser;
  logic [1:0]        tdest;

  modport master (
    output tvalid, tdata, tkeep, tlast, tuser, tdest,
    input  tready
  );

  modport slave (
    input  tvalid, tdata, tkeep, tlast, tuser, tdest,
    output tready
  );

endinterface

// File: rtl/axis_demux3_route_state_base.sv
// Handshake tracker for one stream: flags accepted beats and marks the
// first (sop) and last (eop) accepted beat of each packet.
module axis_state_base (
  input  logic clk,
  input  logic rst_n,
  input  logic tvalid,
  input  logic tready,
  input  logic tlast,
  output logic trn,
  output logic sop,
  output logic eop
);

  logic in_pkt_q;
  logic in_pkt_d;

  always_comb begin
    trn      = tvalid & tready;
    sop      = trn & ~in_pkt_q;
    eop      = trn & tlast;
    in_pkt_d = in_pkt_q;
    if (trn) begin
      in_pkt_d = ~tlast;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      in_pkt_q <= 1'b0;
    end else begin
      in_pkt_q <= in_pkt_d;
    end
  end

endmodule

// File: rtl/axis_demux3_route.sv
// 1:3 AXI-Stream packet demux: each packet is steered whole to m0/m1/m2 by the
// tdest of its first beat, or dropped (tdest=3 or disabled output) and counted.
module axis_demux3_route
  import axis_demux3_route_pkg::*;
#(
  parameter int DATA_W = 512,
  parameter int KEEP_W = DATA_W / 8,
  parameter int USER_W = 1,
  parameter int CNT_W  = 16
) (
  input  logic                aclk,
  input  logic                areset,
  axis_demux3_route_if.slave  s0,
  axis_demux3_route_if.master m0,
  axis_demux3_route_if.master m1,
  axis_demux3_route_if.master m2,
  input  logic                m0_disable,
  input  logic                m1_disable,
  input  logic                m2_disable,
  output logic [CNT_W-1:0]    drop_cnt
);

  state_e            state_q, state_d;
  ch_e               lock_q, lock_d;
  ch_e               hold_dest_q, hold_dest_d;
  ch_e               load_dest;
  logic              hold_vld_q, hold_vld_d;
  logic [DATA_W-1:0] hold_data_q, hold_data_d;
  logic [KEEP_W-1:0] hold_keep_q, hold_keep_d;
  logic              hold_last_q, hold_last_d;
  logic [USER_W-1:0] hold_user_q, hold_user_d;
  logic [CNT_W-1:0]  drop_cnt_q, drop_cnt_d;

  logic       trn, sop, eop;
  logic [2:0] m_ready;
  logic [3:0] dis_vec;
  logic       sel_ready, hold_free, s0_ready, route_ok, load;

  assign m_ready   = {m2.tready, m1.tready, m0.tready};
  assign sel_ready = |(hold_dest_q & m_ready);
  assign hold_free = ~hold_vld_q | sel_ready;
  // Dropped beats bypass the holding register, so DROP never back-pressures.
  assign s0_ready  = ~areset & ((state_q == DROP) | hold_free);
  assign s0.tready = s0_ready;

  // Bit 3 stands for the discard destination, which is never routable.
  assign dis_vec  = {1'b1, m2_disable, m1_disable, m0_disable};
  assign route_ok = (s0.tdest != DEST_DISCARD) & ~dis_vec[s0.tdest];

  axis_state_base u_state_base (
    .clk    (aclk),
    .rst_n  (~areset),
    .tvalid (s0.tvalid),
    .tready (s0_ready),
    .tlast  (s0.tlast),
    .trn    (trn),
    .sop    (sop),
    .eop    (eop)
  );

  always_comb begin
    state_d     = state_q;
    lock_d      = lock_q;
    hold_dest_d = hold_dest_q;
    hold_vld_d  = hold_vld_q & ~sel_ready;
    hold_data_d = hold_data_q;
    hold_keep_d = hold_keep_q;
    hold_last_d = hold_last_q;
    hold_user_d = hold_user_q;
    drop_cnt_d  = drop_cnt_q;
    load        = 1'b0;
    load_dest   = CH_NONE;

    unique case (state_q)
      IDLE: begin
        if (sop) begin
          if (route_ok) begin
            load      = 1'b1;
            load_dest = dest_to_ch(s0.tdest);
            lock_d    = eop ? CH_NONE : load_dest;
            state_d   = eop ? IDLE : ROUTE;
          end else begin
            if (drop_cnt_q != {CNT_W{1'b1}}) begin
              drop_cnt_d = drop_cnt_q + 1'b1;
            end
            state_d = eop ? IDLE : DROP;
          end
        end
      end
      ROUTE: begin
        if (trn) begin
          load      = 1'b1;
          load_dest = lock_q;
          if (eop) begin
            lock_d  = CH_NONE;
            state_d = IDLE;
          end
        end
      end
      DROP: begin
        if (eop) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (load) begin
      hold_vld_d  = 1'b1;
      hold_dest_d = load_dest;
      hold_data_d = s0.tdata;
      hold_keep_d = s0.tkeep;
      hold_last_d = s0.tlast;
      hold_user_d = s0.tuser;
    end
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q     <= IDLE;
      lock_q      <= CH_NONE;
      hold_dest_q <= CH_NONE;
      hold_vld_q  <= 1'b0;
      drop_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      lock_q      <= lock_d;
      hold_dest_q <= hold_dest_d;
      hold_vld_q  <= hold_vld_d;
      drop_cnt_q  <= drop_cnt_d;
    end
  end

  // Payload needs no reset: it is only observed while hold_vld_q is set.
  always_ff @(posedge aclk) begin
    hold_data_q <= hold_data_d;
    hold_keep_q <= hold_keep_d;
    hold_last_q <= hold_last_d;
    hold_user_q <= hold_user_d;
  end

  assign m0.tvalid = hold_vld_q & hold_dest_q[0];
  assign m1.tvalid = hold_vld_q & hold_dest_q[1];
  assign m2.tvalid = hold_vld_q & hold_dest_q[2];

  assign m0.tdata = hold_data_q;
  assign m1.tdata = hold_data_q;
  assign m2.tdata = hold_data_q;
  assign m0.tkeep = hold_keep_q;
  assign m1.tkeep = hold_keep_q;
  assign m2.tkeep = hold_keep_q;
  assign m0.tlast = hold_last_q;
  assign m1.tlast = hold_last_q;
  assign m2.tlast = hold_last_q;
  assign m0.tuser = hold_user_q;
  assign m1.tuser = hold_user_q;
  assign m2.tuser = hold_user_q;
  assign m0.tdest = 2'd0;
  assign m1.tdest = 2'd1;
  assign m2.tdest = 2'd2;

  assign drop_cnt = drop_cnt_q;

endmodule

// File: tb/tb_axis_demux3_route.sv
// Directed bench for axis_demux3_route: a vector table for streaming/routing/drop
// cases plus hand-written stall, reset and counter-saturation sequences.
module tb_axis_demux3_route;

  localparam int DATA_W = 512;
  localparam int KEEP_W = DATA_W / 8;
  localparam int USER_W = 1;
  localparam int CNT_W  = 16;

  typedef struct {
    logic [1:0]       dest;
    logic             last;
    int               id;
    logic [2:0]       dis;
    logic [2:0]       exp_vld;
    logic [CNT_W-1:0] exp_drop;
  } vec_t;

  logic             aclk;
  logic             areset;
  logic             m0_disable, m1_disable, m2_disable;
  logic [CNT_W-1:0] drop_cnt;

  int n_checks;
  int n_fail;
  vec_t vecs[$];
  logic [DATA_W-1:0] m1_log[$];

  axis_demux3_route_if #(.DATA_W(DATA_W), .KEEP_W(KEEP_W), .USER_W(USER_W)) s0_if ();
  axis_demux3_route_if #(.DATA_W(DATA_W), .KEEP_W(KEEP_W), .USER_W(USER_W)) m0_if ();
  axis_demux3_route_if #(.DATA_W(DATA_W), .KEEP_W(KEEP_W), .USER_W(USER_W)) m1_if ();
  axis_demux3_route_if #(.DATA_W(DATA_W), .KEEP_W(KEEP_W), .USER_W(USER_W)) m2_if ();

  axis_demux3_route #(
    .DATA_W (DATA_W),
    .KEEP_W (KEEP_W),
    .USER_W (USER_W),
    .CNT_W  (CNT_W)
  ) dut (
    .aclk       (aclk),
    .areset     (areset),
    .s0         (s0_if.slave),
    .m0         (m0_if.master),
    .m1         (m1_if.master),
    .m2         (m2_if.master),
    .m0_disable (m0_disable),
    .m1_disable (m1_disable),
    .m2_disable (m2_disable),
    .drop_cnt   (drop_cnt)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  always @(posedge aclk) begin
    if (m1_if.tvalid && m1_if.tready) begin
      m1_log.push_back(m1_if.tdata);
    end
  end

  initial begin
    #3000000;
    $display("[TB] FAIL watchdog: simulation time limit reached, got no end expected $finish");
    $fatal(1, "[TB] timeout");
  end

  function automatic logic [DATA_W-1:0] mk_data(input int id);
    logic [DATA_W-1:0] d;
    for (int i = 0; i < DATA_W / 32; i++) begin
      d[i*32 +: 32] = (id * 32'h01010101) + i;
    end
    return d;
  endfunction

  function automatic logic [KEEP_W-1:0] mk_keep(input int id);
    logic [7:0] b;
    b = id[7:0] ^ 8'h5A;
    return {(KEEP_W / 8){b}};
  endfunction

  task automatic check_eq(input string name, input logic [DATA_W-1:0] act,
                          input logic [DATA_W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add_vec(input logic [1:0] dest, input logic last, input int id,
                         input logic [2:0] dis, input logic [2:0] exp_vld,
                         input logic [CNT_W-1:0] exp_drop);
    vec_t v;
    v.dest = dest; v.last = last; v.id = id; v.dis = dis;
    v.exp_vld = exp_vld; v.exp_drop = exp_drop;
    vecs.push_back(v);
  endtask

  task automatic apply_stimulus(input logic [1:0] dest, input logic last, input int id);
    s0_if.tvalid = 1'b1;
    s0_if.tdest  = dest;
    s0_if.tlast  = last;
    s0_if.tdata  = mk_data(id);
    s0_if.tkeep  = mk_keep(id);
    s0_if.tuser  = id[0];
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic check_output(input vec_t v, input int idx);
    logic [2:0]        vld;
    logic [DATA_W-1:0] d;
    logic [KEEP_W-1:0] k;
    logic              l;
    logic [USER_W-1:0] u;
    vld = {m2_if.tvalid, m1_if.tvalid, m0_if.tvalid};
    check_eq($sformatf("vec%0d tvalid", idx), DATA_W'(vld), DATA_W'(v.exp_vld));
    check_eq($sformatf("vec%0d drop_cnt", idx), DATA_W'(drop_cnt), DATA_W'(v.exp_drop));
    if (v.exp_vld != 3'b000) begin
      case (v.exp_vld)
        3'b010:  begin d = m1_if.tdata; k = m1_if.tkeep; l = m1_if.tlast; u = m1_if.tuser; end
        3'b100:  begin d = m2_if.tdata; k = m2_if.tkeep; l = m2_if.tlast; u = m2_if.tuser; end
        default: begin d = m0_if.tdata; k = m0_if.tkeep; l = m0_if.tlast; u = m0_if.tuser; end
      endcase
      check_eq($sformatf("vec%0d tdata", idx), d, mk_data(v.id));
      check_eq($sformatf("vec%0d tkeep", idx), DATA_W'(k), DATA_W'(mk_keep(v.id)));
      check_eq($sformatf("vec%0d tlast", idx), DATA_W'(l), DATA_W'(v.last));
      check_eq($sformatf("vec%0d tuser", idx), DATA_W'(u), DATA_W'(v.id[0]));
    end
  endtask

  task automatic check_idle_outputs(input string tag, input logic [CNT_W-1:0] exp_drop);
    check_eq({tag, " tvalid"}, DATA_W'({m2_if.tvalid, m1_if.tvalid, m0_if.tvalid}), '0);
    check_eq({tag, " drop_cnt"}, DATA_W'(drop_cnt), DATA_W'(exp_drop));
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    areset   = 1'b1;
    m0_disable = 1'b0; m1_disable = 1'b0; m2_disable = 1'b0;
    s0_if.tvalid = 1'b0; s0_if.tdest = 2'd0; s0_if.tlast = 1'b0;
    s0_if.tdata = '0; s0_if.tkeep = '0; s0_if.tuser = '0;
    m0_if.tready = 1'b1; m1_if.tready = 1'b1; m2_if.tready = 1'b1;

    // Reset state
    tick();
    tick();
    check_idle_outputs("reset", '0);
    check_eq("reset s0_tready", DATA_W'(s0_if.tready), '0);
    areset = 1'b0;
    #1;

    // Three 4-beat packets, one per output, back to back
    for (int p = 0; p < 3; p++) begin
      for (int b = 0; b < 4; b++) begin
        add_vec(p[1:0], (b == 3), 16 * p + b + 1, 3'b000, 3'(1 << p), 16'd0);
      end
    end
    // m2 disabled: 2-beat packet to m2 and single-beat discard packet both dropped
    add_vec(2'd2, 1'b0, 8'h40, 3'b100, 3'b000, 16'd1);
    add_vec(2'd2, 1'b1, 8'h41, 3'b100, 3'b000, 16'd1);
    add_vec(2'd3, 1'b1, 8'h42, 3'b100, 3'b000, 16'd2);
    // Mid-packet tdest change and m0_disable are ignored
    add_vec(2'd0, 1'b0, 8'h50, 3'b000, 3'b001, 16'd2);
    add_vec(2'd2, 1'b0, 8'h51, 3'b001, 3'b001, 16'd2);
    add_vec(2'd2, 1'b0, 8'h52, 3'b001, 3'b001, 16'd2);
    add_vec(2'd2, 1'b1, 8'h53, 3'b001, 3'b001, 16'd2);
    // Back-to-back single-beat packets
    add_vec(2'd0, 1'b1, 8'h60, 3'b000, 3'b001, 16'd2);
    add_vec(2'd1, 1'b1, 8'h61, 3'b000, 3'b010, 16'd2);
    add_vec(2'd2, 1'b1, 8'h62, 3'b000, 3'b100, 16'd2);
    add_vec(2'd0, 1'b1, 8'h63, 3'b000, 3'b001, 16'd2);

    for (int i = 0; i < vecs.size(); i++) begin
      apply_stimulus(vecs[i].dest, vecs[i].last, vecs[i].id);
      {m2_disable, m1_disable, m0_disable} = vecs[i].dis;
      #1;
      check_eq($sformatf("vec%0d s0_tready", i), DATA_W'(s0_if.tready), DATA_W'(1));
      tick();
      check_output(vecs[i], i);
    end
    s0_if.tvalid = 1'b0;
    {m2_disable, m1_disable, m0_disable} = 3'b000;
    tick();
    check_idle_outputs("flush", 16'd2);

    // m1 stalls for 5 cycles while beat 2 of a 3-beat packet is held
    m1_log.delete();
    apply_stimulus(2'd1, 1'b0, 8'h90);
    tick();
    apply_stimulus(2'd1, 1'b0, 8'h91);
    tick();
    m1_if.tready = 1'b0;
    apply_stimulus(2'd1, 1'b1, 8'h92);
    #1;
    for (int c = 0; c < 5; c++) begin
      check_eq($sformatf("stall%0d s0_tready", c), DATA_W'(s0_if.tready), '0);
      check_eq($sformatf("stall%0d m1_tvalid", c), DATA_W'(m1_if.tvalid), DATA_W'(1));
      check_eq($sformatf("stall%0d m1_tdata", c), m1_if.tdata, mk_data(8'h91));
      tick();
    end
    m1_if.tready = 1'b1;
    #1;
    check_eq("unstall s0_tready", DATA_W'(s0_if.tready), DATA_W'(1));
    tick();
    s0_if.tvalid = 1'b0;
    check_eq("unstall m1_tdata", m1_if.tdata, mk_data(8'h92));
    check_eq("unstall m1_tlast", DATA_W'(m1_if.tlast), DATA_W'(1));
    tick();
    check_eq("stall m1 drained", DATA_W'(m1_if.tvalid), '0);
    check_eq("stall beat count", DATA_W'(m1_log.size()), DATA_W'(3));
    if (m1_log.size() == 3) begin
      check_eq("stall beat0", m1_log[0], mk_data(8'h90));
      check_eq("stall beat1", m1_log[1], mk_data(8'h91));
      check_eq("stall beat2", m1_log[2], mk_data(8'h92));
    end

    // Reset in the middle of a 4-beat packet to m1
    apply_stimulus(2'd1, 1'b0, 8'h70);
    tick();
    apply_stimulus(2'd1, 1'b0, 8'h71);
    tick();
    s0_if.tvalid = 1'b0;
    areset = 1'b1;
    #1;
    check_eq("midreset s0_tready", DATA_W'(s0_if.tready), '0);
    tick();
    check_idle_outputs("midreset", '0);
    areset = 1'b0;
    apply_stimulus(2'd2, 1'b0, 8'h80);
    #1;
    check_eq("postreset s0_tready", DATA_W'(s0_if.tready), DATA_W'(1));
    tick();
    check_eq("postreset tvalid", DATA_W'({m2_if.tvalid, m1_if.tvalid, m0_if.tvalid}),
             DATA_W'(3'b100));
    check_eq("postreset m2_tdata", m2_if.tdata, mk_data(8'h80));
    apply_stimulus(2'd0, 1'b1, 8'h81);
    tick();
    s0_if.tvalid = 1'b0;
    check_eq("postreset tail tvalid", DATA_W'({m2_if.tvalid, m1_if.tvalid, m0_if.tvalid}),
             DATA_W'(3'b100));
    check_eq("postreset tail m2_tdata", m2_if.tdata, mk_data(8'h81));
    tick();
    check_idle_outputs("postreset drained", '0);

    // Drop counter saturation: 2^16+3 single-beat discard packets
    apply_stimulus(2'd3, 1'b1, 8'hA0);
    for (int n = 0; n < 65534; n++) begin
      tick();
    end
    check_eq("sat 65534", DATA_W'(drop_cnt), DATA_W'(16'hFFFE));
    tick();
    check_eq("sat 65535", DATA_W'(drop_cnt), DATA_W'(16'hFFFF));
    for (int n = 0; n < 4; n++) begin
      tick();
    end
    s0_if.tvalid = 1'b0;
    check_eq("sat 65539", DATA_W'(drop_cnt), DATA_W'(16'hFFFF));
    check_eq("sat tvalid", DATA_W'({m2_if.tvalid, m1_if.tvalid, m0_if.tvalid}), '0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
